// File: rtl/left_key_cond.sv
// rtl/left_key_cond.sv - four-key synchroniser, debouncer, press/release/long-press events and mode latch
// Optional feature macro: LEFT_KEY_LONG_PRESS_EN (hold counters, LONG state and KEY_LONG pulses).
module left_key_cond #(
    parameter int DEBOUNCE_CYC = 240000,
    parameter int LONG_CYC     = 72000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] KEY_RAW,
    output logic [3:0] KEY_LEVEL,
    output logic [3:0] KEY_PRESS,
    output logic [3:0] KEY_RELEASE,
    output logic [3:0] KEY_LONG,
    output logic [3:0] MODE_SEL,
    output logic       MODE_VALID
);

    // Reject parameter values the 20-bit and 27-bit counters cannot represent.
    generate
        if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 1048575 ||
            LONG_CYC < 1 || LONG_CYC > 134217727) begin : g_bad_param
            $error("left_key_cond: DEBOUNCE_CYC or LONG_CYC out of range");
        end
    endgenerate

    localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYC - 1);

`ifdef LEFT_KEY_LONG_PRESS_EN
    localparam logic [26:0] LONG_LAST = 27'(LONG_CYC - 1);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;
`endif

    logic [3:0]  r_sync1;
    logic [3:0]  r_sync2;
    logic [3:0]  r_level;
    logic [19:0] r_dcnt [4];
    logic [3:0]  r_press;
    logic [3:0]  r_release;
    logic [3:0]  r_mode_sel;
    logic        r_mode_valid;
    state_t      r_state [4];
    state_t      w_state_nxt [4];
    logic [3:0]  w_tog;
    logic [3:0]  w_press;
    logic [3:0]  w_release;
    logic [3:0]  w_mode_onehot;
`ifdef LEFT_KEY_LONG_PRESS_EN
    logic [26:0] r_hcnt [4];
    logic [3:0]  r_long;
    logic [3:0]  w_long;
`endif

    // Two-flop synchroniser for the asynchronous raw buttons.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= KEY_RAW;
            r_sync2 <= r_sync1;
        end
    end

    // A key's debounced level flips once its synchronised input has differed for DEBOUNCE_CYC cycles.
    always_comb begin
        w_tog = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_tog[i] = (r_sync2[i] != r_level[i]) && (r_dcnt[i] == DEB_LAST);
        end
    end

    // Debounce counters restart on any bounce back to the current level and after each accepted change.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_level <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_dcnt[i] <= 20'd0;
            end
        end else begin
            r_level <= r_level ^ w_tog;
            for (int i = 0; i < 4; i++) begin
                if ((r_sync2[i] == r_level[i]) || w_tog[i]) begin
                    r_dcnt[i] <= 20'd0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 20'd1;
                end
            end
        end
    end

    // Per-key state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
        end
    end

    // Per-key next state; a debounced fall always beats the long-press threshold.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (w_tog[i]) w_state_nxt[i] = ST_HELD;
                end
                ST_HELD: begin
                    if (w_tog[i]) begin
                        w_state_nxt[i] = ST_IDLE;
`ifdef LEFT_KEY_LONG_PRESS_EN
                    end else if (r_hcnt[i] == LONG_LAST) begin
                        w_state_nxt[i] = ST_LONG;
`endif
                    end
                end
`ifdef LEFT_KEY_LONG_PRESS_EN
                ST_LONG: begin
                    if (w_tog[i]) w_state_nxt[i] = ST_IDLE;
                end
`endif
                default: w_state_nxt[i] = ST_IDLE;
            endcase
        end
    end

    // Per-key event decode; level is low exactly in IDLE, so a toggle there is a press.
    always_comb begin
        w_press   = 4'b0000;
        w_release = 4'b0000;
`ifdef LEFT_KEY_LONG_PRESS_EN
        w_long    = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            case (r_state[i])
                ST_IDLE: w_press[i] = w_tog[i];
                ST_HELD: begin
                    w_release[i] = w_tog[i];
`ifdef LEFT_KEY_LONG_PRESS_EN
                    w_long[i]    = !w_tog[i] && (r_hcnt[i] == LONG_LAST);
`endif
                end
`ifdef LEFT_KEY_LONG_PRESS_EN
                ST_LONG: w_release[i] = w_tog[i];
`endif
                default: w_press[i] = 1'b0;
            endcase
        end
    end

    // Register the event pulses so they line up with the level change.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_press   <= 4'b0000;
            r_release <= 4'b0000;
        end else begin
            r_press   <= w_press;
            r_release <= w_release;
        end
    end

`ifdef LEFT_KEY_LONG_PRESS_EN
    // Hold counters run only in HELD, freeze in LONG so the long pulse cannot repeat, and clear in IDLE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_long <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_hcnt[i] <= 27'd0;
            end
        end else begin
            r_long <= w_long;
            for (int i = 0; i < 4; i++) begin
                if (r_state[i] == ST_HELD) begin
                    r_hcnt[i] <= r_hcnt[i] + 27'd1;
                end else if (r_state[i] == ST_IDLE) begin
                    r_hcnt[i] <= 27'd0;
                end
            end
        end
    end

    assign KEY_LONG = r_long;
`else
    assign KEY_LONG = 4'b0000;
`endif

    // Lowest-index key among this cycle's presses selects the mode.
    always_comb begin
        w_mode_onehot = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (r_press[i]) begin
                w_mode_onehot    = 4'b0000;
                w_mode_onehot[i] = 1'b1;
            end
        end
    end

    // Mode latch, loaded only by presses.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_mode_sel   <= 4'b0000;
            r_mode_valid <= 1'b0;
        end else if (r_press != 4'b0000) begin
            r_mode_sel   <= w_mode_onehot;
            r_mode_valid <= 1'b1;
        end
    end

    assign KEY_LEVEL   = r_level;
    assign KEY_PRESS   = r_press;
    assign KEY_RELEASE = r_release;
    assign MODE_SEL    = r_mode_sel;
    assign MODE_VALID  = r_mode_valid;

endmodule

// File: doc/left_key_cond.md
# left_key_cond

- Conditions the four raw LEFT_KEY push-buttons before they reach the text-LCD/mode logic.
- Per key: synchronises, debounces, and emits level, press/release pulses and a long-press pulse.
- Also holds a one-hot "current mode" register selected by the most recent press.
- Sits directly upstream of the LCD mode/menu stage, which consumes clean single-cycle events instead of raw levels.

## Interface
- DEBOUNCE_CYC, 240000, consecutive stable CLK cycles required to accept a level change (10 ms @ 24 MHz); legal 1..1048575.
- LONG_CYC, 72000000, cycles of continuous debounced hold before the long-press pulse (3 s @ 24 MHz); legal 1..134217727.
- CLK  in  1  system clock, 24 MHz.
- RESET  in  1  asynchronous, active-high reset.
- KEY_RAW  in  4  raw buttons, active-high, asynchronous to CLK, bouncing.
- KEY_LEVEL  out  4  debounced level per key.
- KEY_PRESS  out  4  one-cycle pulse on debounced rising edge.
- KEY_RELEASE  out  4  one-cycle pulse on debounced falling edge.
- KEY_LONG  out  4  one-cycle pulse when a key has been held LONG_CYC cycles.
- MODE_SEL  out  4  one-hot latched mode; 0 until first press.
- MODE_VALID  out  1  high once any press has been accepted since reset.

## Operation
- Sync: each KEY_RAW bit passes through a 2-flop synchroniser (reset 0) to give s[i].
- Debounce, per key, uses a 20-bit counter dcnt[i]:
  - If s[i] == KEY_LEVEL[i]: dcnt[i] is cleared.
  - Otherwise dcnt[i] increments.
  - When dcnt[i] == DEBOUNCE_CYC-1 and s[i] still differs: KEY_LEVEL[i] toggles on the next edge and dcnt[i] clears.
- Per-key state machine:
  - IDLE -> HELD on debounced rise; KEY_PRESS[i]=1 in the same cycle KEY_LEVEL[i] rises.
  - HELD -> LONG when the hold counter reaches LONG_CYC-1; KEY_LONG[i]=1 for that one cycle.
  - HELD or LONG -> IDLE on debounced fall; KEY_RELEASE[i]=1 in the same cycle KEY_LEVEL[i] falls.
- Hold counter: 27 bits, cleared in IDLE, increments in HELD, frozen in LONG. Exactly one KEY_LONG per press, never repeating.
- Mode latch: on any cycle with KEY_PRESS != 0, MODE_SEL is loaded one-hot with the lowest-index pressed key and MODE_VALID is set. Releases and long pulses do not change MODE_SEL.
- Simultaneous press and release on different keys in one cycle: both pulses are emitted independently.
- Reset mid-operation:
  - All outputs, counters and states clear immediately.
  - A key still held after reset deasserts is detected as a fresh press after sync + debounce.

## Timing
- All outputs registered; reset values are 0 for KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_LONG, MODE_SEL and MODE_VALID.
- Press latency: raw stable edge -> KEY_LEVEL/KEY_PRESS = 2 + DEBOUNCE_CYC cycles. Release latency is identical.
- MODE_SEL/MODE_VALID update 1 cycle after KEY_PRESS.
- KEY_LONG is asserted exactly LONG_CYC cycles after the KEY_PRESS cycle of the same key.
- A glitch shorter than DEBOUNCE_CYC synchronised cycles produces no output change; dcnt restarts from 0 on each bounce.
- If release debounce completes in the same cycle the hold counter would reach LONG_CYC-1, release wins and no KEY_LONG is emitted.

## Configuration
- LEFT_KEY_LONG_PRESS_EN defined: hold counters, LONG state and KEY_LONG logic are compiled in as described.
- Not defined:
  - The hold counter and the LONG state are removed; KEY_LONG is tied to 4'b0000.
  - State machine is IDLE/HELD only; all other behaviour is unchanged.

## Test plan
All scenarios use DEBOUNCE_CYC=4, LONG_CYC=20, macro defined unless stated.
- Reset: assert RESET mid-count with KEY_RAW=4'b0100 -> all outputs 0 immediately. After release with the key still held: KEY_PRESS[2] pulses at cycle 6, MODE_SEL=4'b0100 at cycle 7.
- Bounce: KEY_RAW[0] toggles 1,0,1,0 with 3-cycle periods, then holds 1 -> no pulses during toggling; a single KEY_PRESS[0] 6 cycles after the final rise; a single KEY_RELEASE[0] 6 cycles after a clean fall.
- Long press: hold KEY_RAW[2] for 40 cycles -> KEY_PRESS[2] at t, one KEY_LONG[2] at t+20, none afterwards; KEY_RELEASE[2] after the fall. Holding 15 cycles -> no KEY_LONG.
- Simultaneous: KEY_RAW 4'b0000 -> 4'b1010 on one edge -> KEY_PRESS=4'b1010 in a single cycle, MODE_SEL=4'b0010, MODE_VALID=1.
- Mode sequence: press key3, release, press key0 -> MODE_SEL goes 4'b1000 then 4'b0001; releases leave MODE_SEL unchanged.
- Macro undefined: repeat the long-press scenario -> KEY_LONG stays 4'b0000; press/release timing identical.
